oven_controller: RTL

Sequencing controller for the oven simulator. It latches the temperature setpoint assembled by the temperature-entry logic and a bake duration, then runs the oven through preheat, bake and done phases. It models the oven cavity temperature with a tick-based heat/cool ramp, drives the heater enable, and counts the bake time down. It sits between the user-input blocks (temperature entry, buttons) and the display/beeper outputs.

---
 rtl/oven_controller.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/oven_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | oven_controller: preheat/bake/done sequencer with tick-based cavity model |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module oven_controller #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int RAMP_STEP  = 5,
  parameter int COOL_STEP  = 2,
  parameter int AMBIENT    = 70,
  parameter int MAX_TEMP   = 550,
  parameter int BEEP_TICKS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  setpoint,
  input  logic [11:0] bake_time,
  input  logic        start,
  input  logic        cancel,
  output logic        heater_on,
  output logic [9:0]  cur_temp,
  output logic [11:0] time_left,
  output logic [1:0]  state,
  output logic        done_beep
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREHEAT = 2'd1,
    BAKE    = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_TICKS - 1);
  localparam logic [10:0]   RAMP11    = 11'(RAMP_STEP);
  localparam logic [10:0]   FLOOR11   = 11'(AMBIENT + COOL_STEP);
  localparam logic [9:0]    COOL10    = 10'(COOL_STEP);
  localparam logic [9:0]    AMB10     = 10'(AMBIENT);
  localparam logic [9:0]    MAX10     = 10'(MAX_TEMP);

  state_t          cur_st, nxt_st;
  logic            start_q, cancel_q;
  logic [TW-1:0]   tick_cnt;
  logic [9:0]      target, target_n, temp_n;
  logic [11:0]     time_n;
  logic [BW-1:0]   beep_cnt, beep_n;
  logic            heater_n;
  logic [10:0]     sum11;
  logic            tick, start_rise, cancel_rise;

  assign tick        = (tick_cnt == TICK_LAST);
  assign start_rise  = start & ~start_q;
  assign cancel_rise = cancel & ~cancel_q;
  assign sum11       = {1'b0, cur_temp} + RAMP11;
  assign state       = cur_st;

  always_comb begin
    temp_n   = cur_temp;
    nxt_st   = cur_st;
    target_n = target;
    time_n   = time_left;
    beep_n   = beep_cnt;
    heater_n = 1'b0;

    // Cavity model runs off the registered heater state, independent of the FSM
    if (tick) begin
      if (heater_on) begin
        temp_n = (sum11 > {1'b0, target}) ? target : sum11[9:0];
      end else if (cur_temp > AMB10) begin
        temp_n = ({1'b0, cur_temp} >= FLOOR11) ? (cur_temp - COOL10) : AMB10;
      end
    end

    unique case (cur_st)
      IDLE: begin
        if (!cancel_rise && start_rise && (bake_time != 12'd0) && (setpoint != 10'd0)) begin
          nxt_st   = PREHEAT;
          target_n = (setpoint > MAX10) ? MAX10 : setpoint;
          time_n   = bake_time;
        end
      end
      PREHEAT: begin
        if (cancel_rise) begin
          nxt_st = IDLE;
          time_n = 12'd0;
        end else if (cur_temp >= target) begin
          nxt_st = BAKE;
        end
      end
      BAKE: begin
        if (cancel_rise) begin
          nxt_st = IDLE;
          time_n = 12'd0;
        end else if (time_left == 12'd0) begin
          nxt_st = DONE;
          beep_n = '0;
        end else if (tick) begin
          time_n = time_left - 12'd1;
        end
      end
      DONE: begin
        if (cancel_rise || start_rise) begin
          nxt_st = IDLE;
          beep_n = '0;
        end else if (tick) begin
          if (beep_cnt == BEEP_LAST) begin
            nxt_st = IDLE;
            beep_n = '0;
          end else begin
            beep_n = beep_cnt + BW'(1);
          end
        end
      end
      default: nxt_st = IDLE;
    endcase

    // Heater decision uses the post-edge state and temperature
    unique case (nxt_st)
      PREHEAT: heater_n = 1'b1;
      BAKE:    heater_n = (temp_n < target_n);
      default: heater_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_q   <= 1'b1;
      cancel_q  <= 1'b1;
      tick_cnt  <= '0;
      cur_st    <= IDLE;
      target    <= AMB10;
      cur_temp  <= AMB10;
      time_left <= 12'd0;
      beep_cnt  <= '0;
      heater_on <= 1'b0;
      done_beep <= 1'b0;
    end else begin
      start_q   <= start;
      cancel_q  <= cancel;
      tick_cnt  <= tick ? '0 : tick_cnt + TW'(1);
      cur_st    <= nxt_st;
      target    <= target_n;
      cur_temp  <= temp_n;
      time_left <= time_n;
      beep_cnt  <= beep_n;
      heater_on <= heater_n;
      done_beep <= (nxt_st == DONE);
    end
  end

endmodule
`default_nettype wire
